// File: rtl/csi_rx_link_ctrl.sv
// CSI-2 receive link supervisor: sequences datapath reset, LP->HS entry and frame lock, re-locks on loss.
// Optional statistics counters are built only when CSI_LINK_CTRL_STATS_EN is defined.
module csi_rx_link_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter logic [23:0] ACQ_TIMEOUT   = 24'd2000000,
  parameter logic [23:0] FRAME_TIMEOUT = 24'd4000000,
  parameter int unsigned ERR_LIMIT     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        lp_detect,
  input  logic        vsync,
  input  logic        hdr_ok,
  input  logic        hdr_err,
  output logic        dp_reset,
  output logic        link_up,
  output logic        relock,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
);

  localparam logic [2:0] S_RST_HOLD = 3'd0;
  localparam logic [2:0] S_WAIT_LP  = 3'd1;
  localparam logic [2:0] S_WAIT_HS  = 3'd2;
  localparam logic [2:0] S_ACQUIRE  = 3'd3;
  localparam logic [2:0] S_LOCKED   = 3'd4;
  localparam logic [2:0] S_RELOCK   = 3'd5;

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [3:0] ERR_LIM  = 4'(ERR_LIMIT);

  logic [2:0]  state_q, state_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [23:0] timer_q, timer_d;
  logic [3:0]  err_run_q, err_run_d;
  logic [3:0]  err_run_inc;
  logic        dp_reset_q, dp_reset_d;
  logic        link_up_q, link_up_d;
  logic        relock_q, relock_d;

  assign err_run_inc = err_run_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    timer_d   = timer_q;
    err_run_d = err_run_q;
    if (enable) begin
      case (state_q)
        S_RST_HOLD: begin
          timer_d   = '0;
          err_run_d = '0;
          if (rst_cnt_q == RST_LAST) begin
            state_d   = S_WAIT_LP;
            rst_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 8'd1;
          end
        end
        S_WAIT_LP: begin
          if (lp_detect) state_d = S_WAIT_HS;
        end
        S_WAIT_HS: begin
          if (!lp_detect) begin
            state_d = S_ACQUIRE;
            timer_d = '0;
          end
        end
        S_ACQUIRE: begin
          // A frame start in the timeout cycle still counts as acquisition.
          if (vsync) begin
            state_d = S_LOCKED;
            timer_d = '0;
          end else if (timer_q == ACQ_TIMEOUT) begin
            state_d = S_RELOCK;
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
        S_LOCKED: begin
          if (vsync) begin
            timer_d = '0;
          end else if (timer_q == FRAME_TIMEOUT) begin
            state_d = S_RELOCK;
          end else begin
            timer_d = timer_q + 24'd1;
          end
          // A rejected header outranks an accepted one in the same cycle.
          if (hdr_err) begin
            err_run_d = err_run_inc;
            if (err_run_inc == ERR_LIM) state_d = S_RELOCK;
          end else if (hdr_ok) begin
            err_run_d = '0;
          end
        end
        S_RELOCK: begin
          state_d   = S_RST_HOLD;
          rst_cnt_d = '0;
          timer_d   = '0;
          err_run_d = '0;
        end
        default: begin
          state_d   = S_RST_HOLD;
          rst_cnt_d = '0;
          timer_d   = '0;
          err_run_d = '0;
        end
      endcase
    end
    dp_reset_d = (state_d == S_RST_HOLD) || (state_d == S_RELOCK);
    link_up_d  = (state_d == S_LOCKED);
    relock_d   = (state_d == S_RELOCK);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_RST_HOLD;
      rst_cnt_q  <= '0;
      timer_q    <= '0;
      err_run_q  <= '0;
      dp_reset_q <= 1'b1;
      link_up_q  <= 1'b0;
      relock_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      timer_q    <= timer_d;
      err_run_q  <= err_run_d;
      dp_reset_q <= dp_reset_d;
      link_up_q  <= link_up_d;
      relock_q   <= relock_d;
    end
  end

  assign dp_reset = dp_reset_q;
  assign link_up  = link_up_q;
  assign relock   = relock_q;

`ifdef CSI_LINK_CTRL_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
    if (enable) begin
      if (vsync && ((state_q == S_ACQUIRE) || (state_q == S_LOCKED))
          && (frame_count_q != 16'hFFFF))
        frame_count_d = frame_count_q + 16'd1;
      if (hdr_err && (state_q != S_RST_HOLD) && (state_q != S_RELOCK)
          && (err_count_q != 16'hFFFF))
        err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
`else
  assign frame_count = 16'h0000;
  assign err_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_csi_rx_link_ctrl.sv
// Scenario bench for csi_rx_link_ctrl: expectations are queued as stimulus is driven and
// popped against the registered outputs one time unit after each active edge.
module tb_csi_rx_link_ctrl;

  logic        clock = 1'b0;
  logic        reset, enable, lp_detect, vsync, hdr_ok, hdr_err;
  logic        dp_reset, link_up, relock;
  logic [15:0] frame_count, err_count;

`ifdef CSI_LINK_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [34:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_fc = 0;
  int   exp_ec = 0;

  csi_rx_link_ctrl #(
    .RST_CYCLES   (16),
    .ACQ_TIMEOUT  (24'd20),
    .FRAME_TIMEOUT(24'd100),
    .ERR_LIMIT    (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .lp_detect  (lp_detect),
    .vsync      (vsync),
    .hdr_ok     (hdr_ok),
    .hdr_err    (hdr_err),
    .dp_reset   (dp_reset),
    .link_up    (link_up),
    .relock     (relock),
    .frame_count(frame_count),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  function automatic logic [34:0] observed();
    return {dp_reset, link_up, relock, frame_count, err_count};
  endfunction

  function automatic void expect_out(string name, logic dp, logic lu, logic rl);
    exp_t e;
    e.name = name;
    e.v    = {dp, lu, rl, STATS ? 16'(exp_fc) : 16'h0, STATS ? 16'(exp_ec) : 16'h0};
    sb.push_back(e);
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; enable = 1'b1; lp_detect = 1'b0;
    vsync = 1'b0; hdr_ok = 1'b0; hdr_err = 1'b0;
    expect_out("reset_state", 1'b1, 1'b0, 1'b0);
    step(2);
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      hdr_err = (i == 5);  // rejected header during RST_HOLD is not counted
      expect_out((i < 16) ? "rst_hold" : "dp_reset_fall", (i < 16), 1'b0, 1'b0);
      step(1);
      hdr_err = 1'b0;
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin errors++; $display("FAIL %s cyc %0d got %h want %h", e.name, i, observed(), e.v); end
      else $display("ok %s cyc %0d", e.name, i);
    end
    hdr_err = 1'b1; vsync = 1'b1;
    exp_ec++;
    expect_out("wait_lp_stats", 1'b0, 1'b0, 1'b0);
    step(1);
    hdr_err = 1'b0; vsync = 1'b0;
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
  endtask

  task automatic test_acquire();
    exp_t e;
    lp_detect = 1'b1;
    expect_out("wait_hs", 1'b0, 1'b0, 1'b0);
    step(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
    lp_detect = 1'b0;
    step(1);
    step(9);
    expect_out("pre_lock", 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
    vsync = 1'b1;
    exp_fc++;
    expect_out("link_up", 1'b0, 1'b1, 1'b0);
    step(1);
    vsync = 1'b0;
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
  endtask

  task automatic test_err_limit();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      hdr_err = (i != 3);
      hdr_ok  = (i == 3);
      if (i != 3) exp_ec++;
      expect_out("err_run", 1'b0, 1'b1, 1'b0);
      step(1);
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin errors++; $display("FAIL %s idx %0d got %h want %h", e.name, i, observed(), e.v); end
      else $display("ok %s idx %0d", e.name, i);
    end
    hdr_err = 1'b1; hdr_ok = 1'b1;  // both in one cycle: the error must win
    exp_ec++;
    expect_out("err_relock", 1'b1, 1'b0, 1'b1);
    step(1);
    hdr_err = 1'b0; hdr_ok = 1'b0;
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
    for (int i = 1; i <= 17; i++) begin
      expect_out("relock_hold", (i < 17), 1'b0, 1'b0);
      step(1);
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin errors++; $display("FAIL %s cyc %0d got %h want %h", e.name, i, observed(), e.v); end
      else $display("ok %s cyc %0d", e.name, i);
    end
  endtask

  task automatic test_frame_timeout();
    exp_t e;
    test_acquire();
    step(99);
    expect_out("locked_at_limit", 1'b0, 1'b1, 1'b0);
    step(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
    expect_out("frame_timeout", 1'b1, 1'b0, 1'b1);
    step(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
    step(16);
    expect_out("relock_done", 1'b0, 1'b0, 1'b0);
    step(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    test_acquire();
    step(100);
    for (int i = 0; i < 4; i++) begin
      vsync = 1'b1;  // first pulse lands in the cycle the timer equals the limit
      exp_fc++;
      expect_out((i == 0) ? "vsync_beats_timeout" : "vsync_b2b", 1'b0, 1'b1, 1'b0);
      step(1);
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin errors++; $display("FAIL %s idx %0d got %h want %h", e.name, i, observed(), e.v); end
      else $display("ok %s idx %0d", e.name, i);
    end
    vsync = 1'b0;
    step(59);
    expect_out("timer_restarted", 1'b0, 1'b1, 1'b0);
    step(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
  endtask

  task automatic test_midop_reset();
    exp_t e;
    reset = 1'b1;
    exp_fc = 0; exp_ec = 0;
    expect_out("midop_reset", 1'b1, 1'b0, 1'b0);
    step(1);
    reset = 1'b0;
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
    step(14);
    expect_out("rst_hold_last", 1'b1, 1'b0, 1'b0);
    step(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
    expect_out("dp_fall_again", 1'b0, 1'b0, 1'b0);
    step(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
  endtask

  task automatic test_enable_stall();
    exp_t e;
    lp_detect = 1'b1;
    step(1);
    lp_detect = 1'b0;
    step(1);
    step(5);
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      hdr_err = (i % 10 == 0);
      vsync   = (i == 25);
      expect_out("stall_frozen", 1'b0, 1'b0, 1'b0);
      step(1);
      e = sb.pop_front(); checks++;
      if (observed() !== e.v) begin errors++; $display("FAIL %s cyc %0d got %h want %h", e.name, i, observed(), e.v); end
      else $display("ok %s cyc %0d", e.name, i);
    end
    hdr_err = 1'b0; vsync = 1'b0; enable = 1'b1;
    step(14);
    expect_out("acq_no_timeout", 1'b0, 1'b0, 1'b0);
    step(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
    expect_out("acq_timeout", 1'b1, 1'b0, 1'b1);
    step(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
    step(16);
    expect_out("acq_relock_done", 1'b0, 1'b0, 1'b0);
    step(1);
    e = sb.pop_front(); checks++;
    if (observed() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, observed(), e.v); end
    else $display("ok %s", e.name);
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_err_limit();
    test_frame_timeout();
    test_back_to_back();
    test_midop_reset();
    test_enable_stall();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
